// File: rtl/wrpg.sv
// wrpg: weighted random pattern generator for BIST stimulus.
// An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) advances on each enabled edge.
// Each new state is compared with the weight cin to give a biased bit Y
// (P(Y=1) = cin/255). The last eight weighted bits are shifted into cout.
// Optional feature macro: WRPG_ZERO_GUARD_EN -- when defined, a seed load of
// 8'h00 stores 8'h01 instead so the LFSR can never lock up in the zero state.
module wrpg (
   input  logic       clk,
   input  logic       rst,
   input  logic       set,
   input  logic       en,
   input  logic [7:0] D,
   input  logic [7:0] cin,
   output logic [7:0] cout,
   output logic       Y
);

   logic [7:0] s_q, s_d;
   logic [7:0] cout_q, cout_d;
   logic       y_q, y_d;
   logic [7:0] s_step;
   logic [7:0] seed;
   logic       w;

   // LFSR step, weight compare and seed guard
   always_comb begin
      s_step = {s_q[6:0], s_q[7] ^ s_q[5] ^ s_q[4] ^ s_q[3]};
      w      = (s_step <= cin);
`ifdef WRPG_ZERO_GUARD_EN
      seed   = (D == 8'h00) ? 8'h01 : D;
`else
      seed   = D;
`endif
   end

   // Next-state selection: seed load beats advance; outputs hold on a load
   always_comb begin
      s_d    = s_q;
      cout_d = cout_q;
      y_d    = y_q;
      if (set) begin
         s_d = seed;
      end else if (en) begin
         s_d    = s_step;
         y_d    = w;
         cout_d = {cout_q[6:0], w};
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         s_q    <= 8'h01;
         cout_q <= 8'h00;
         y_q    <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
         y_q    <= y_d;
      end
   end

   assign cout = cout_q;
   assign Y    = y_q;

endmodule

// File: tb/tb_wrpg.sv
// tb_wrpg: scoreboard bench for wrpg. The reference model walks an index
// through the precomputed maximal-length sequence; expected {cout, Y} values
// are queued at drive time and checked by an independent monitor.
module tb_wrpg;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       set = 1'b0;
   logic       en  = 1'b0;
   logic [7:0] D   = 8'h00;
   logic [7:0] cin = 8'h00;
   logic [7:0] cout;
   logic       Y;

   int tests = 0;
   int fails = 0;

   logic [8:0] exp_q[$];

   // Reference model: sequence table plus position in it
   logic [7:0] seq[255];
   int         m_idx;
   bit         m_zero;
   logic [7:0] m_cout;
   logic       m_y;

   wrpg u_dut (
      .clk  (clk),
      .rst  (rst),
      .set  (set),
      .en   (en),
      .D    (D),
      .cin  (cin),
      .cout (cout),
      .Y    (Y)
   );

   always #5 clk = ~clk;

   // Monitor: compare every registered output against the queued expectation
   always @(posedge clk) begin
      logic [8:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tests++;
         if ({cout, Y} !== e) begin
            fails++;
            $display("FAIL scoreboard t=%0t: got cout=%02h Y=%b, want cout=%02h Y=%b",
                     $time, cout, Y, e[8:1], e[0]);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, want);
      end
   endtask

   function automatic int find_idx(input logic [7:0] v);
      for (int i = 0; i < 255; i++) if (seq[i] == v) return i;
      return 0;
   endfunction

   // Apply one edge's inputs, update the model, queue the expectation, and
   // return once the outputs after that edge are settled.
   task automatic cyc(input logic r, input logic s, input logic e, input logic [7:0] d,
                      input logic [7:0] c);
      logic [7:0] st;
      logic       w;
      @(negedge clk);
      rst = r; set = s; en = e; D = d; cin = c;
      if (!r) begin
         m_idx = 0; m_zero = 1'b0; m_cout = 8'h00; m_y = 1'b0;
      end else if (s) begin
`ifdef WRPG_ZERO_GUARD_EN
         m_zero = 1'b0;
         m_idx  = (d == 8'h00) ? 0 : find_idx(d);
`else
         m_zero = (d == 8'h00);
         if (d != 8'h00) m_idx = find_idx(d);
`endif
      end else if (e) begin
         if (m_zero) st = 8'h00;
         else begin
            m_idx = (m_idx + 1) % 255;
            st    = seq[m_idx];
         end
         w      = (int'(st) <= int'(c));
         m_y    = w;
         m_cout = {m_cout[6:0], w};
      end
      exp_q.push_back({m_cout, m_y});
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [7:0] v;
      int ones;
      int n;
      // Build the state sequence of x^8+x^6+x^5+x^4+1 starting from 0x01
      v = 8'h01;
      for (int i = 0; i < 255; i++) begin
         seq[i] = v;
         v = {v[6:0], ^(v & 8'hB8)};
      end
      m_idx = 0; m_zero = 1'b0; m_cout = 8'h00; m_y = 1'b0;

      // Reset wins over set and en
      cyc(1'b0, 1'b1, 1'b1, 8'h55, 8'hFF);
      check("reset_cout", cout, 8'h00);
      check("reset_y", Y, 1'b0);

      // cin=FF: every step yields one
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'hFF);
         check("seq_y", Y, 1'b1);
      end
      check("seq_cout", cout, 8'h0F);

      // cin=05 from reset: states 02,04,08,11 -> 1,1,0,0
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h05);
         check("weight5_y", Y, (i < 2) ? 1'b1 : 1'b0);
      end
      check("weight5_cout", cout, 8'h0C);

      // cin=00: never one
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
      check("weight0_cout", cout, 8'h00);

      // Seed priority over enable, then advance from the seed, then hold
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'hFF);
      cyc(1'b1, 1'b1, 1'b1, 8'h11, 8'hFF);
      check("seed_hold_cout", cout, 8'h07);
      check("seed_hold_y", Y, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h20);
      check("seed_adv_y", Y, 1'b0);
      check("seed_adv_cout", cout, 8'h0E);
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF);
      check("idle_cout", cout, 8'h0E);
      check("idle_y", Y, 1'b0);

      // Zero seed
      cyc(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
`ifdef WRPG_ZERO_GUARD_EN
      cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h02);
      check("zero_guard_y", Y, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h02);
      check("zero_guard_y2", Y, 1'b0);
`else
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
         check("zero_lock_y", Y, 1'b1);
      end
      check("zero_lock_cout", cout, 8'hFF);
`endif

      // Full period with cin=80: 128 ones, state returns to 01
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      ones = 0;
      for (int i = 0; i < 255; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h80);
         if (Y === 1'b1) ones++;
      end
      check("period_ones", ones, 128);
      cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h02);
      check("period_wrap_y", Y, 1'b1);

      // Randomized traffic checked by the scoreboard
      for (int i = 0; i < 500; i++) begin
         n = $urandom_range(0, 99);
         v = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
         cyc((n < 3) ? 1'b0 : 1'b1, (n >= 3 && n < 12) ? 1'b1 : 1'b0,
             ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, v, 8'($urandom));
      end

      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
